// File: rtl/clk_ratio_meter_if.sv
// clk_ratio_meter_if: groups the measured divided clock, the enable and the
// measurement results of clk_ratio_meter. The master side drives the divided
// clock and enable; the slave side is the meter itself.
interface clk_ratio_meter_if #(
    parameter int RATIO_WIDTH = 8
);
    logic                   i_div_clk;
    logic                   i_en;
    logic [RATIO_WIDTH-1:0] o_ratio;
    logic [RATIO_WIDTH-1:0] o_high_cnt;
    logic                   o_valid;
    logic                   o_locked;
    logic                   o_timeout;

    modport master (
        output i_div_clk,
        output i_en,
        input  o_ratio,
        input  o_high_cnt,
        input  o_valid,
        input  o_locked,
        input  o_timeout
    );

    modport slave (
        input  i_div_clk,
        input  i_en,
        output o_ratio,
        output o_high_cnt,
        output o_valid,
        output o_locked,
        output o_timeout
    );
endinterface

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: turns a divided clock (synchronous to i_clk) back into its
// division ratio. Reports the period in i_clk cycles, the number of high
// samples per period, and valid / lock / timeout status.
// Optional feature macro: CLK_RATIO_METER_DUTY_EN builds the high-time counter;
// when it is undefined o_high_cnt is tied to 0.
module clk_ratio_meter #(
    parameter int RATIO_WIDTH = 8,
    parameter int LOCK_CNT    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    clk_ratio_meter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [RATIO_WIDTH-1:0] CNT_ONE     = RATIO_WIDTH'(1);
    localparam logic [3:0]             LOCK_TARGET = 4'(LOCK_CNT);

    state_t                 state;
    logic                   prev;
    logic                   div_edge;
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] high_q;
    logic                   valid_q;
    logic                   locked_q;
    logic                   timeout_q;
    logic [3:0]             match_cnt;
    logic [3:0]             match_next;
    logic                   period_match;

    // The divided clock comes from i_clk registers, so a single delayed
    // sample is enough to find its rising edge.
    assign div_edge     = bus.i_div_clk & ~prev;
    assign period_match = (cnt == ratio_q);
    assign match_next   = (match_cnt < LOCK_TARGET) ? match_cnt + 4'd1 : match_cnt;

    // Previous sample of the divided clock, tracked even while disabled so
    // that re-enabling on a high level does not fake an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= bus.i_div_clk;
        end
    end

    // Period counter: restarts at 1 on every edge, held at 0 while idle so a
    // static input can never time out there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!bus.i_en) begin
            cnt <= '0;
        end else if (div_edge) begin
            cnt <= CNT_ONE;
        end else if (state == IDLE || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Measurement FSM with registered results: capture on edges, lock on a
    // run of equal periods, and drop back to IDLE on disable or timeout.
    // An edge coinciding with the maximum count is a capture, not a timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ratio_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            match_cnt <= 4'd0;
        end else if (!bus.i_en) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            match_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_edge) begin
                        state <= FIRST;
                    end
                end
                FIRST, TRACK: begin
                    if (div_edge) begin
                        state     <= TRACK;
                        ratio_q   <= cnt;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        if (state == TRACK && period_match) begin
                            match_cnt <= match_next;
                            locked_q  <= (match_next == LOCK_TARGET);
                        end else begin
                            match_cnt <= 4'd1;
                            locked_q  <= (state == FIRST) && (LOCK_TARGET == 4'd1);
                        end
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b0;
                        locked_q  <= 1'b0;
                        match_cnt <= 4'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CLK_RATIO_METER_DUTY_EN
    logic [RATIO_WIDTH-1:0] hcnt;
    logic [RATIO_WIDTH-1:0] div_inc;

    assign div_inc = RATIO_WIDTH'(bus.i_div_clk);

    // High-sample counter: the edge sample itself is high, so it restarts
    // at 1 and then adds every further high sample of the period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hcnt <= '0;
        end else if (!bus.i_en) begin
            hcnt <= '0;
        end else if (div_edge) begin
            hcnt <= CNT_ONE;
        end else if (state == IDLE || cnt == CNT_MAX) begin
            hcnt <= '0;
        end else begin
            hcnt <= hcnt + div_inc;
        end
    end

    // High count is captured alongside the period on every measuring edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            high_q <= '0;
        end else if (bus.i_en && state != IDLE && div_edge) begin
            high_q <= hcnt;
        end
    end
`else
    assign high_q = '0;
`endif

    assign bus.o_ratio    = ratio_q;
    assign bus.o_high_cnt = high_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_locked   = locked_q;
    assign bus.o_timeout  = timeout_q;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: drives directed and random divided-clock patterns into
// clk_ratio_meter and compares every cycle against a period-level model
// built from edge timestamps and a history of measured periods.
// Honors CLK_RATIO_METER_DUTY_EN for the expected high count.
module tb_clk_ratio_meter;
    localparam int RATIO_WIDTH = 8;
    localparam int LOCK_CNT    = 2;
    localparam int MAX_PERIOD  = (1 << RATIO_WIDTH) - 1;
`ifdef CLK_RATIO_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    bit   check_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    clk_ratio_meter_if #(.RATIO_WIDTH(RATIO_WIDTH)) bus ();

    clk_ratio_meter #(
        .RATIO_WIDTH(RATIO_WIDTH),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: when the last edge happened, how many high samples since,
    // and the periods measured since tracking started.
    int       cycle_no = 0;
    int       last_edge = 0;
    int       ones = 0;
    int       m_age = 0;
    bit       m_prev = 1'b0;
    bit       m_armed = 1'b0;
    bit       m_sample;
    bit       m_edge;
    int       periods[$];
    logic [7:0] exp_ratio = 8'd0;
    logic [7:0] exp_high = 8'd0;
    logic       exp_valid = 1'b0;
    logic       exp_locked = 1'b0;
    logic       exp_timeout = 1'b0;

    function automatic bit lastPeriodsEqual();
        int n;
        n = periods.size();
        if (n < LOCK_CNT) return 1'b0;
        for (int k = 1; k < LOCK_CNT; k++) begin
            if (periods[n-1-k] != periods[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model, advanced on every rising edge of the reference clock.
    always @(posedge clk) begin
        cycle_no++;
        if (!rst_n) begin
            m_prev      = 1'b0;
            m_armed     = 1'b0;
            periods.delete();
            exp_ratio   = 8'd0;
            exp_high    = 8'd0;
            exp_valid   = 1'b0;
            exp_locked  = 1'b0;
            exp_timeout = 1'b0;
        end else begin
            m_sample = bus.i_div_clk;
            m_edge   = m_sample && !m_prev;
            m_prev   = m_sample;
            if (!bus.i_en) begin
                m_armed    = 1'b0;
                periods.delete();
                exp_valid  = 1'b0;
                exp_locked = 1'b0;
            end else if (!m_armed) begin
                if (m_edge) begin
                    m_armed   = 1'b1;
                    last_edge = cycle_no;
                    ones      = 1;
                end
            end else begin
                m_age = cycle_no - last_edge;
                if (m_edge) begin
                    exp_ratio   = 8'(m_age);
                    exp_high    = DUTY ? 8'(ones) : 8'd0;
                    exp_valid   = 1'b1;
                    exp_timeout = 1'b0;
                    periods.push_back(m_age);
                    if (periods.size() > 16) void'(periods.pop_front());
                    exp_locked  = lastPeriodsEqual();
                    last_edge   = cycle_no;
                    ones        = 1;
                end else if (m_age >= MAX_PERIOD) begin
                    exp_timeout = 1'b1;
                    exp_valid   = 1'b0;
                    exp_locked  = 1'b0;
                    m_armed     = 1'b0;
                    periods.delete();
                end else begin
                    ones += int'(m_sample);
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (bus.o_ratio !== exp_ratio || bus.o_high_cnt !== exp_high ||
                bus.o_valid !== exp_valid || bus.o_locked !== exp_locked ||
                bus.o_timeout !== exp_timeout) begin
                errors++;
                $display("[TB] FAIL outputs cycle %0d: got ratio=%0d high=%0d valid=%b locked=%b timeout=%b, expected ratio=%0d high=%0d valid=%b locked=%b timeout=%b",
                         cycle_no, bus.o_ratio, bus.o_high_cnt, bus.o_valid, bus.o_locked, bus.o_timeout,
                         exp_ratio, exp_high, exp_valid, exp_locked, exp_timeout);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One reference cycle: drive now, let the DUT sample it, return past the next falling edge.
    task automatic driveCycle(input bit div, input bit en);
        bus.i_div_clk = div;
        bus.i_en      = en;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int period, input int high, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < period; i++) begin
                driveCycle(i < high, 1'b1);
            end
        end
    endtask

    int kind;
    int p;
    int h;
    bit lvl;

    initial begin
        rst_n         = 1'b0;
        bus.i_div_clk = 1'b0;
        bus.i_en      = 1'b0;
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        #1;
        driveCycle(1'b0, 1'b0);
        driveCycle(1'b0, 1'b0);
        checkOutput("reset ratio", int'(bus.o_ratio), 0);
        checkOutput("reset valid", int'(bus.o_valid), 0);
        checkOutput("reset locked", int'(bus.o_locked), 0);
        checkOutput("reset timeout", int'(bus.o_timeout), 0);
        rst_n = 1'b1;

        // Ratio 2: valid at the 2nd rising edge, lock at the 3rd.
        applyStimulus(2, 1, 1);
        checkOutput("ratio2 valid before 2nd edge", int'(bus.o_valid), 0);
        driveCycle(1'b1, 1'b1);
        checkOutput("ratio2 valid", int'(bus.o_valid), 1);
        checkOutput("ratio2 ratio", int'(bus.o_ratio), 2);
        checkOutput("ratio2 model ratio", int'(exp_ratio), 2);
        checkOutput("ratio2 high", int'(bus.o_high_cnt), DUTY ? 1 : 0);
        checkOutput("ratio2 not yet locked", int'(bus.o_locked), 0);
        driveCycle(1'b0, 1'b1);
        driveCycle(1'b1, 1'b1);
        checkOutput("ratio2 locked at 3rd edge", int'(bus.o_locked), 1);

        // 2 high / 3 low.
        driveCycle(1'b0, 1'b1);
        applyStimulus(5, 2, 4);
        checkOutput("ratio5 ratio", int'(bus.o_ratio), 5);
        checkOutput("ratio5 high", int'(bus.o_high_cnt), DUTY ? 2 : 0);
        checkOutput("ratio5 model high", int'(exp_high), DUTY ? 2 : 0);
        checkOutput("ratio5 locked", int'(bus.o_locked), 1);

        // Locked at 4, switch to 7.
        applyStimulus(4, 2, 4);
        checkOutput("ratio4 locked", int'(bus.o_locked), 1);
        checkOutput("ratio4 ratio", int'(bus.o_ratio), 4);
        applyStimulus(7, 3, 1);
        checkOutput("ratio7 pending still locked", int'(bus.o_locked), 1);
        driveCycle(1'b1, 1'b1);
        checkOutput("ratio7 mismatch unlocks", int'(bus.o_locked), 0);
        checkOutput("ratio7 ratio", int'(bus.o_ratio), 7);
        driveCycle(1'b1, 1'b1);
        driveCycle(1'b1, 1'b1);
        repeat (4) driveCycle(1'b0, 1'b1);
        driveCycle(1'b1, 1'b1);
        checkOutput("ratio7 relock", int'(bus.o_locked), 1);
        checkOutput("ratio7 model locked", int'(exp_locked), 1);

        // Locked at 3, then held low until timeout.
        driveCycle(1'b1, 1'b1);
        driveCycle(1'b1, 1'b1);
        repeat (4) driveCycle(1'b0, 1'b1);
        applyStimulus(3, 1, 4);
        checkOutput("ratio3 locked", int'(bus.o_locked), 1);
        repeat (252) driveCycle(1'b0, 1'b1);
        checkOutput("timeout not yet at 254", int'(bus.o_timeout), 0);
        checkOutput("valid held at 254", int'(bus.o_valid), 1);
        driveCycle(1'b0, 1'b1);
        checkOutput("timeout at 255", int'(bus.o_timeout), 1);
        checkOutput("timeout clears valid", int'(bus.o_valid), 0);
        checkOutput("timeout clears locked", int'(bus.o_locked), 0);
        checkOutput("timeout holds ratio", int'(bus.o_ratio), 3);
        applyStimulus(3, 1, 1);
        checkOutput("timeout sticky after 1st edge", int'(bus.o_timeout), 1);
        driveCycle(1'b1, 1'b1);
        checkOutput("timeout cleared at 2nd edge", int'(bus.o_timeout), 0);
        checkOutput("resumed ratio3", int'(bus.o_ratio), 3);
        driveCycle(1'b0, 1'b1);
        driveCycle(1'b0, 1'b1);

        // Period of exactly the maximum count.
        applyStimulus(MAX_PERIOD, 1, 2);
        checkOutput("ratio255 ratio", int'(bus.o_ratio), 255);
        checkOutput("ratio255 no timeout", int'(bus.o_timeout), 0);
        driveCycle(1'b1, 1'b1);
        checkOutput("ratio255 edge at max no timeout", int'(bus.o_timeout), 0);
        checkOutput("ratio255 locked", int'(bus.o_locked), 1);

        // Reset while in FIRST with ratio 6.
        driveCycle(1'b0, 1'b0);
        checkOutput("disable holds ratio", int'(bus.o_ratio), 255);
        applyStimulus(6, 3, 1);
        checkOutput("first state ratio held", int'(bus.o_ratio), 255);
        rst_n = 1'b0;
        driveCycle(1'b0, 1'b1);
        checkOutput("midreset ratio", int'(bus.o_ratio), 0);
        checkOutput("midreset high", int'(bus.o_high_cnt), 0);
        checkOutput("midreset valid", int'(bus.o_valid), 0);
        rst_n = 1'b1;
        applyStimulus(6, 3, 1);
        checkOutput("after reset valid before 2nd edge", int'(bus.o_valid), 0);
        driveCycle(1'b1, 1'b1);
        checkOutput("after reset valid", int'(bus.o_valid), 1);
        checkOutput("after reset ratio6", int'(bus.o_ratio), 6);
        checkOutput("after reset high", int'(bus.o_high_cnt), DUTY ? 3 : 0);

        // Enable low for 3 cycles while locked.
        driveCycle(1'b1, 1'b1);
        driveCycle(1'b1, 1'b1);
        repeat (3) driveCycle(1'b0, 1'b1);
        applyStimulus(6, 3, 2);
        checkOutput("ratio6 locked", int'(bus.o_locked), 1);
        driveCycle(1'b0, 1'b0);
        checkOutput("disable clears valid", int'(bus.o_valid), 0);
        checkOutput("disable clears locked", int'(bus.o_locked), 0);
        driveCycle(1'b0, 1'b0);
        driveCycle(1'b0, 1'b0);
        checkOutput("disable holds ratio6", int'(bus.o_ratio), 6);
        applyStimulus(6, 3, 1);
        driveCycle(1'b1, 1'b1);
        checkOutput("reenable valid", int'(bus.o_valid), 1);
        checkOutput("reenable ratio6", int'(bus.o_ratio), 6);

        // Random segments checked by the model every cycle.
        for (int seg = 0; seg < 150; seg++) begin
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                rst_n = 1'b0;
                driveCycle(1'($urandom_range(0, 1)), 1'b1);
                rst_n = 1'b1;
            end else if (kind == 1) begin
                repeat ($urandom_range(1, 4)) driveCycle(1'($urandom_range(0, 1)), 1'b0);
            end else if (kind == 2) begin
                lvl = 1'($urandom_range(0, 1));
                repeat ($urandom_range(20, 300)) driveCycle(lvl, 1'b1);
            end else if (kind == 3) begin
                repeat ($urandom_range(5, 30)) driveCycle(1'($urandom_range(0, 1)), 1'b1);
            end else if (kind == 4) begin
                p = int'($urandom_range(240, 270));
                h = int'($urandom_range(1, 3));
                applyStimulus(p, h, int'($urandom_range(1, 2)));
            end else begin
                p = int'($urandom_range(2, 24));
                h = int'($urandom_range(1, p - 1));
                applyStimulus(p, h, int'($urandom_range(1, 6)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
